// File: rtl/vga_timing_controller_if.sv
// Pixel interface between the display timing controller and the drawing blocks.
// The controller issues coordinates and ticks; the drawers return one color per tick.
interface vga_timing_controller_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        pixelEn;
    logic        startOfFrame;
    logic [7:0]  pixelRGB;

    modport master (
        output pixelX,
        output pixelY,
        output pixelEn,
        output startOfFrame,
        input  pixelRGB
    );

    modport slave (
        input  pixelX,
        input  pixelY,
        input  pixelEn,
        input  startOfFrame,
        output pixelRGB
    );
endinterface

// File: rtl/vga_timing_controller.sv
// 640x480@60Hz raster timing generator: issues pixel coordinates to the drawers,
// samples their color one tick later and drives registered DAC, sync and blanking pins.
module vga_timing_controller #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned CLK_DIV     = 2,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic                          clk,
    input  logic                          resetN,
    vga_timing_controller_if.master       pix,
    output logic [3:0]                    vgaR,
    output logic [3:0]                    vgaG,
    output logic [3:0]                    vgaB,
    output logic                          hSync,
    output logic                          vSync,
    output logic                          blankN
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int unsigned CNT_W    = 11;
    localparam int unsigned DIV_W    = 3;

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             pixel_en_q;
    logic             sof_q;

    logic             tick_c;
    logic             h_wrap_c;
    logic             v_wrap_c;
    logic             vis_c;
    logic             hs_c;
    logic             vs_c;
    logic [2:0]       red_c;
    logic [2:0]       green_c;
    logic [1:0]       blue_c;

    assign tick_c   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_wrap_c = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_wrap_c = (v_cnt == CNT_W'(V_TOTAL - 1));

    // Region decodes of the coordinate currently presented to the drawers
    assign vis_c = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
    assign hs_c  = (h_cnt >= CNT_W'(HS_FIRST)) && (h_cnt <= CNT_W'(HS_LAST));
    assign vs_c  = (v_cnt >= CNT_W'(VS_FIRST)) && (v_cnt <= CNT_W'(VS_LAST));

    assign red_c   = pix.pixelRGB[7:5];
    assign green_c = pix.pixelRGB[4:2];
    assign blue_c  = pix.pixelRGB[1:0];

    assign pix.pixelX       = h_cnt;
    assign pix.pixelY       = v_cnt;
    assign pix.pixelEn      = pixel_en_q;
    assign pix.startOfFrame = sof_q;

    // Pixel-rate divider and frame-start pulse; these are the only per-clk state
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_cnt    <= '0;
            pixel_en_q <= 1'b0;
            sof_q      <= 1'b0;
        end else begin
            div_cnt    <= tick_c ? '0 : div_cnt + DIV_W'(1);
            pixel_en_q <= tick_c;
            sof_q      <= tick_c && h_wrap_c && v_wrap_c;
        end
    end

    // Stage 1: raster counters, advanced once per pixel tick
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick_c) begin
            if (h_wrap_c) begin
                h_cnt <= '0;
                v_cnt <= v_wrap_c ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 2: color for the previous coordinate arrives now, so decodes are
    // registered alongside it to keep sync, blanking and color aligned
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vgaR   <= 4'h0;
            vgaG   <= 4'h0;
            vgaB   <= 4'h0;
            hSync  <= ~SYNC_ACTIVE;
            vSync  <= ~SYNC_ACTIVE;
            blankN <= 1'b0;
        end else if (tick_c) begin
            vgaR   <= vis_c ? {red_c, red_c[2]}     : 4'h0;
            vgaG   <= vis_c ? {green_c, green_c[2]} : 4'h0;
            vgaB   <= vis_c ? {blue_c, blue_c}      : 4'h0;
            hSync  <= hs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vSync  <= vs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            blankN <= vis_c;
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: full-size timing instance for line/color checks, and a
// shrunken raster instance (CLK_DIV = 1) for frame-level sync and reset checks.
module tb_vga_timing_controller;

    logic clk;
    logic rst0;
    logic rst1;
    logic rgb_mode;
    int   n_cmp;
    int   n_err;

    logic [3:0] vgaR0, vgaG0, vgaB0, vgaR1, vgaG1, vgaB1;
    logic       hSync0, vSync0, blankN0, hSync1, vSync1, blankN1;

    vga_timing_controller_if pif0 ();
    vga_timing_controller_if pif1 ();

    vga_timing_controller u_dut (
        .clk    (clk),
        .resetN (rst0),
        .pix    (pif0),
        .vgaR   (vgaR0),
        .vgaG   (vgaG0),
        .vgaB   (vgaB0),
        .hSync  (hSync0),
        .vSync  (vSync0),
        .blankN (blankN0)
    );

    // Small raster: H 8/2/3/2 (15), V 6/2/2/3 (13), one pixel per clk
    vga_timing_controller #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .CLK_DIV   (1), .SYNC_ACTIVE (1'b0)
    ) u_small (
        .clk    (clk),
        .resetN (rst1),
        .pix    (pif1),
        .vgaR   (vgaR1),
        .vgaG   (vgaG1),
        .vgaB   (vgaB1),
        .hSync  (hSync1),
        .vSync  (vSync1),
        .blankN (blankN1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drawer stand-in: white everywhere, or a marker color at (10,5) and white at (11,5)
    always_comb begin
        pif0.pixelRGB = 8'hFF;
        if (rgb_mode) begin
            if (pif0.pixelX == 11'd10 && pif0.pixelY == 11'd5)
                pif0.pixelRGB = 8'b100_010_01;
            else if (pif0.pixelX == 11'd11 && pif0.pixelY == 11'd5)
                pif0.pixelRGB = 8'hFF;
            else
                pif0.pixelRGB = 8'h00;
        end
    end

    assign pif1.pixelRGB = 8'b101_001_10;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst0 = 1'b0;
        rst1 = 1'b0;
        rgb_mode = 1'b0;
        step(3);
        n_cmp++;
        if ({pif0.pixelX, pif0.pixelY} !== 22'd0) begin
            n_err++; $display("FAIL reset_coord: got %0d,%0d expected 0,0", pif0.pixelX, pif0.pixelY);
        end
        n_cmp++;
        if ({pif0.pixelEn, pif0.startOfFrame} !== 2'b00) begin
            n_err++; $display("FAIL reset_en_sof: got %b%b expected 00", pif0.pixelEn, pif0.startOfFrame);
        end
        n_cmp++;
        if ({vgaR0, vgaG0, vgaB0} !== 12'h000) begin
            n_err++; $display("FAIL reset_color: got %h%h%h expected 000", vgaR0, vgaG0, vgaB0);
        end
        n_cmp++;
        if ({hSync0, vSync0, blankN0} !== 3'b110) begin
            n_err++; $display("FAIL reset_sync_blank: got %b%b%b expected 110", hSync0, vSync0, blankN0);
        end
        n_cmp++;
        if ({hSync1, vSync1, blankN1, pif1.pixelEn} !== 4'b1100) begin
            n_err++; $display("FAIL reset_small: got %b%b%b%b expected 1100", hSync1, vSync1, blankN1, pif1.pixelEn);
        end
    endtask

    task automatic test_divider();
        rst0 = 1'b1;
        step(1);
        n_cmp++;
        if ({pif0.pixelEn, pif0.pixelX, blankN0} !== {1'b0, 11'd0, 1'b0}) begin
            n_err++; $display("FAIL div_edge1: got en=%b x=%0d blank=%b expected en=0 x=0 blank=0", pif0.pixelEn, pif0.pixelX, blankN0);
        end
        step(1);
        n_cmp++;
        if ({pif0.pixelEn, pif0.pixelX, blankN0, vgaR0} !== {1'b1, 11'd1, 1'b1, 4'hF}) begin
            n_err++; $display("FAIL div_edge2: got en=%b x=%0d blank=%b r=%h expected en=1 x=1 blank=1 r=f", pif0.pixelEn, pif0.pixelX, blankN0, vgaR0);
        end
        step(1);
        n_cmp++;
        if ({pif0.pixelEn, pif0.pixelX} !== {1'b0, 11'd1}) begin
            n_err++; $display("FAIL div_edge3: got en=%b x=%0d expected en=0 x=1", pif0.pixelEn, pif0.pixelX);
        end
        step(1595);
        n_cmp++;
        if ({pif0.pixelX, pif0.pixelY} !== {11'd799, 11'd0}) begin
            n_err++; $display("FAIL line_end: got %0d,%0d expected 799,0", pif0.pixelX, pif0.pixelY);
        end
        step(2);
        n_cmp++;
        if ({pif0.pixelX, pif0.pixelY, pif0.pixelEn} !== {11'd0, 11'd1, 1'b1}) begin
            n_err++; $display("FAIL line_wrap: got %0d,%0d en=%b expected 0,1 en=1", pif0.pixelX, pif0.pixelY, pif0.pixelEn);
        end
    endtask

    task automatic test_hsync_line();
        int hs_low, hs_first, bl_high, bl_first_low, vis_bad, blank_bad, en_bad, vs_low, sof_seen;
        hs_low = 0; hs_first = -1; bl_high = 0; bl_first_low = -1;
        vis_bad = 0; blank_bad = 0; en_bad = 0; vs_low = 0; sof_seen = 0;
        for (int i = 1; i <= 800; i++) begin
            step(2);
            if (pif0.pixelEn !== 1'b1) en_bad++;
            if (vSync0 !== 1'b1) vs_low++;
            if (pif0.startOfFrame !== 1'b0) sof_seen++;
            if (hSync0 === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(pif0.pixelX);
            end
            if (blankN0 === 1'b1) begin
                bl_high++;
                if ({vgaR0, vgaG0, vgaB0} !== 12'hFFF) vis_bad++;
            end else begin
                if (bl_first_low < 0) bl_first_low = int'(pif0.pixelX);
                if ({vgaR0, vgaG0, vgaB0} !== 12'h000) blank_bad++;
            end
        end
        n_cmp++;
        if (hs_first !== 657) begin
            n_err++; $display("FAIL hsync_start: got %0d expected 657", hs_first);
        end
        n_cmp++;
        if (hs_low !== 96) begin
            n_err++; $display("FAIL hsync_width: got %0d expected 96", hs_low);
        end
        n_cmp++;
        if ({bl_high, bl_first_low} !== {32'd640, 32'd641}) begin
            n_err++; $display("FAIL blank_line: got high=%0d first_low=%0d expected 640 641", bl_high, bl_first_low);
        end
        n_cmp++;
        if ({vis_bad, blank_bad} !== 64'd0) begin
            n_err++; $display("FAIL line_color: got vis_bad=%0d blank_bad=%0d expected 0 0", vis_bad, blank_bad);
        end
        n_cmp++;
        if ({en_bad, vs_low, sof_seen} !== 96'd0) begin
            n_err++; $display("FAIL line_misc: got en_bad=%0d vs_low=%0d sof=%0d expected 0 0 0", en_bad, vs_low, sof_seen);
        end
        n_cmp++;
        if ({pif0.pixelX, pif0.pixelY} !== {11'd0, 11'd2}) begin
            n_err++; $display("FAIL line_period: got %0d,%0d expected 0,2", pif0.pixelX, pif0.pixelY);
        end
    endtask

    task automatic test_color();
        bit found;
        found = 1'b0;
        rgb_mode = 1'b1;
        for (int i = 0; i < 20000 && !found; i++) begin
            step(1);
            if (pif0.pixelX == 11'd10 && pif0.pixelY == 11'd5) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL color_wait: got no coordinate (10,5) expected it within 20000 clk");
        end else begin
            step(2);
            n_cmp++;
            if ({vgaR0, vgaG0, vgaB0, blankN0} !== {4'b1001, 4'b0100, 4'b0101, 1'b1}) begin
                n_err++; $display("FAIL color_expand: got %b %b %b blank=%b expected 1001 0100 0101 blank=1", vgaR0, vgaG0, vgaB0, blankN0);
            end
            step(1);
            n_cmp++;
            if ({vgaR0, vgaG0, vgaB0, pif0.pixelX} !== {12'h945, 11'd11}) begin
                n_err++; $display("FAIL color_hold: got %h%h%h x=%0d expected 945 x=11", vgaR0, vgaG0, vgaB0, pif0.pixelX);
            end
            step(1);
            n_cmp++;
            if ({vgaR0, vgaG0, vgaB0} !== 12'hFFF) begin
                n_err++; $display("FAIL color_white: got %h%h%h expected fff", vgaR0, vgaG0, vgaB0);
            end
        end
        rgb_mode = 1'b0;
    endtask

    task automatic test_vertical_frame();
        int c, h, v, vs_low, vs_first, hs_low, bl_high, sof_cnt, sof_bad, coord_bad, sync_bad, color_bad, en_bad;
        vs_low = 0; vs_first = -1; hs_low = 0; bl_high = 0; sof_cnt = 0;
        sof_bad = 0; coord_bad = 0; sync_bad = 0; color_bad = 0; en_bad = 0;
        rst1 = 1'b1;
        for (int k = 1; k <= 390; k++) begin
            step(1);
            c = (k - 1) % 195;
            h = c % 15;
            v = c / 15;
            if (pif1.pixelEn !== 1'b1) en_bad++;
            if (pif1.pixelX !== 11'(k % 15) || pif1.pixelY !== 11'((k / 15) % 13)) coord_bad++;
            if (hSync1 !== ((h >= 10 && h <= 12) ? 1'b0 : 1'b1)) sync_bad++;
            if (vSync1 !== ((v >= 8 && v <= 9) ? 1'b0 : 1'b1)) sync_bad++;
            if (blankN1 !== ((h < 8 && v < 6) ? 1'b1 : 1'b0)) sync_bad++;
            if ({vgaR1, vgaG1, vgaB1} !== ((h < 8 && v < 6) ? 12'hB2A : 12'h000)) color_bad++;
            if (pif1.startOfFrame !== ((k % 195 == 0) ? 1'b1 : 1'b0)) sof_bad++;
            if (pif1.startOfFrame === 1'b1) sof_cnt++;
            if (hSync1 === 1'b0) hs_low++;
            if (blankN1 === 1'b1) bl_high++;
            if (vSync1 === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
        end
        n_cmp++;
        if ({vs_low, vs_first} !== {32'd60, 32'd121}) begin
            n_err++; $display("FAIL vsync_frame: got low=%0d first=%0d expected 60 121", vs_low, vs_first);
        end
        n_cmp++;
        if ({hs_low, bl_high} !== {32'd78, 32'd96}) begin
            n_err++; $display("FAIL frame_counts: got hs_low=%0d vis=%0d expected 78 96", hs_low, bl_high);
        end
        n_cmp++;
        if ({sof_cnt, sof_bad} !== {32'd2, 32'd0}) begin
            n_err++; $display("FAIL sof_pulse: got count=%0d bad=%0d expected 2 0", sof_cnt, sof_bad);
        end
        n_cmp++;
        if ({coord_bad, sync_bad, color_bad, en_bad} !== 128'd0) begin
            n_err++; $display("FAIL frame_samples: got coord=%0d sync=%0d color=%0d en=%0d expected all 0", coord_bad, sync_bad, color_bad, en_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int sof_early, sof_at_end;
        sof_early = 0; sof_at_end = 0;
        step(132);
        n_cmp++;
        if ({hSync1, vSync1} !== 2'b00) begin
            n_err++; $display("FAIL pre_reset_sync: got %b%b expected 00", hSync1, vSync1);
        end
        rst1 = 1'b0;
        #1;
        n_cmp++;
        if ({hSync1, vSync1, blankN1, vgaR1, vgaG1, vgaB1} !== {3'b110, 12'h000}) begin
            n_err++; $display("FAIL async_reset: got %b%b%b %h%h%h expected 110 000", hSync1, vSync1, blankN1, vgaR1, vgaG1, vgaB1);
        end
        n_cmp++;
        if ({pif1.pixelX, pif1.pixelY, pif1.pixelEn} !== 23'd0) begin
            n_err++; $display("FAIL async_reset_coord: got %0d,%0d en=%b expected 0,0 en=0", pif1.pixelX, pif1.pixelY, pif1.pixelEn);
        end
        step(2);
        rst1 = 1'b1;
        step(1);
        n_cmp++;
        if ({pif1.pixelX, pif1.pixelY, hSync1, vSync1} !== {11'd1, 11'd0, 2'b11}) begin
            n_err++; $display("FAIL restart: got %0d,%0d hs=%b vs=%b expected 1,0 hs=1 vs=1", pif1.pixelX, pif1.pixelY, hSync1, vSync1);
        end
        if (pif1.startOfFrame === 1'b1) sof_early++;
        for (int k = 2; k <= 195; k++) begin
            step(1);
            if (k < 195 && pif1.startOfFrame === 1'b1) sof_early++;
            if (k == 195) sof_at_end = int'(pif1.startOfFrame);
        end
        n_cmp++;
        if ({sof_early, sof_at_end} !== {32'd0, 32'd1}) begin
            n_err++; $display("FAIL sof_after_reset: got early=%0d at_195=%0d expected 0 1", sof_early, sof_at_end);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_divider();
        test_hsync_line();
        test_color();
        test_vertical_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Display-side end of the pixel interface used by the drawing blocks (background, sprites, boarders).
- Generates the 640x480@60Hz raster timing and issues pixelX/pixelY to the drawing logic.
- Samples the returned 8-bit RRRGGGBB color one pixel later and drives the registered VGA DAC colors, hSync, vSync and blanking.
- Produces a one-clock start-of-frame pulse for game-logic frame stepping.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (legal range 1..8)
- SYNC_ACTIVE, 1'b0, active level of hSync/vSync

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- pixelRGB  in  8  color from drawing logic for the coordinate issued on the previous pixel tick, {R[2:0],G[2:0],B[1:0]}
- pixelX  out  11  current horizontal count (0..H_TOTAL-1)
- pixelY  out  11  current vertical count (0..V_TOTAL-1)
- pixelEn  out  1  one-clk pixel tick
- startOfFrame  out  1  one-clk pulse when counters wrap to (0,0)
- vgaR  out  4  red DAC
- vgaG  out  4  green DAC
- vgaB  out  4  blue DAC
- hSync  out  1  horizontal sync
- vSync  out  1  vertical sync
- blankN  out  1  high while output pixel is visible

Behaviour:
- Reset is asynchronous on resetN low, clocked on clk.
- Totals: H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800); V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525). Counters are 11 bits unsigned.
- Reset values: divCnt = 0, hCnt = 0, vCnt = 0, pixelEn = 0, startOfFrame = 0, vgaR/G/B = 0, hSync = vSync = ~SYNC_ACTIVE, blankN = 0.
- Divider: divCnt counts 0..CLK_DIV-1 and wraps. pixelEn = (divCnt == CLK_DIV-1), so the first pixelEn falls on clk edge CLK_DIV after reset release. With CLK_DIV = 1, pixelEn is constantly high.
- Stage 1 (on pixelEn):
  - hCnt++.
  - At hCnt == H_TOTAL-1: hCnt <= 0 and vCnt++.
  - At vCnt == V_TOTAL-1 with hCnt wrap: vCnt <= 0.
  - pixelX = hCnt and pixelY = vCnt, driven directly from the counter registers. Coordinates keep counting through blanking; drawers must ignore out-of-frame values.
- startOfFrame: registered, high for exactly one clk on the edge where (hCnt,vCnt) becomes (0,0).
- Decodes from the current counters:
  - vis = hCnt < H_VISIBLE && vCnt < V_VISIBLE.
  - hs = hCnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1].
  - vs = vCnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1].
  - These are registered into a one-tick delay (vis_d, hs_d, vs_d), updated on pixelEn.
- Stage 2 (on pixelEn): pixelRGB is sampled, giving exactly one pixel tick of latency between a coordinate and its color.
  - Colors:
    - vgaR = vis_d ? {R, R[2]} : 0
    - vgaG = vis_d ? {G, G[2]} : 0
    - vgaB = vis_d ? {B, B} : 0
  - blankN = vis_d.
  - hSync = hs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE.
  - vSync = vs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE.
- All outputs hold between pixel ticks. Nothing changes on a clk where pixelEn = 0, except divCnt, pixelEn and startOfFrame.
- Reset mid-line or mid-frame: all state returns to reset values immediately. No partial sync pulse persists, and timing restarts from (0,0) on release.
- pixelRGB during blanking is ignored; the color outputs are forced to 0.

Test Plan:
- Divider and pixel tick: release reset with CLK_DIV = 2 -> pixelEn high on clk edges 2, 4, 6…; after 800 ticks (1600 clk), pixelX returns to 0 and pixelY = 1.
- Horizontal timing: monitor hSync over one line -> low for exactly 96 ticks, starting at output tick 657. This is one tick after the hCnt = 656 decode, from the stage-2 delay. Line period is 800 ticks.
- Vertical timing and frame pulse: run 2 frames -> vSync low for exactly 2 lines (1600 ticks) per frame, starting at line 490. startOfFrame pulses once per 420000 ticks, each pulse a single clk wide.
- Color expansion and latency: drive pixelRGB = 8'b100_010_01 for coordinate (10,5) -> on the next tick, vgaR = 4'b1001, vgaG = 4'b0100, vgaB = 4'b0101 and blankN = 1. pixelRGB = 8'hFF gives F/F/F.
- Blanking: drive pixelRGB = 8'hFF constantly -> at output hCnt 641..799 and at any line >= 480, vgaR/G/B = 0 and blankN = 0.
- Reset mid-operation: assert resetN low at hCnt = 700, vCnt = 491 (inside hSync and vSync) -> outputs return immediately to hSync = vSync = 1 and colors = 0. After release, the first startOfFrame is not issued until a full frame completes.
